uart_prog_loader: RTL

Serial receive path that loads the program memory from a host while the board runs. The top level today only reads program memory and only drives outputs; this block is the write/input end.
- Receives 8N1 UART bytes on an input pin and parses a framed load packet.
- Writes 16-bit words into the program BRAM write port.
- Holds the CPU halted (`loading`) while a frame is in progress and reports done/error for the front panel.

---
 rtl/loader_pkg.sv | 21 ++
 rtl/uart_rx_byte.sv | 108 ++++++++++
 rtl/uart_prog_loader.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared constants and state encodings for the UART program loader.
package loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        LD_SYNC,
        LD_COUNT,
        LD_LO,
        LD_HI,
        LD_CSUM
    } ld_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver with input synchroniser; one-cycle byte_valid / frame_err pulses.
//
// state    | meaning
// RX_IDLE  | line idle, waiting for a synchronised falling edge
// RX_START | half-bit wait, then confirm the start bit is still low
// RX_DATA  | sampling 8 data bits LSB-first, one per bit period
// RX_STOP  | sampling the stop bit; high -> byte_valid, low -> frame_err
module uart_rx_byte
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);

    rx_state_t        state, state_nxt;
    logic             rx_meta, rx_sync, rx_prev;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             tick;
    logic             fall;

    assign tick = (cnt == '0);
    assign fall = rx_prev & ~rx_sync;

    // rx_prev gives the edge detector a third registered stage, all idle-high
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= RX_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RX_IDLE:  if (fall) state_nxt = RX_START;
            RX_START: if (tick) state_nxt = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (tick && bit_idx == 3'd7) state_nxt = RX_STOP;
            RX_STOP:  if (tick) state_nxt = RX_IDLE;
            default:  state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                RX_IDLE: begin
                    cnt     <= HALF_LOAD;
                    bit_idx <= '0;
                end
                RX_START: cnt <= tick ? BIT_LOAD : cnt - 1'b1;
                RX_DATA: begin
                    if (tick) begin
                        shift   <= {rx_sync, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        cnt     <= BIT_LOAD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RX_STOP: begin
                    if (tick) begin
                        if (rx_sync) begin
                            byte_valid <= 1'b1;
                            byte_data  <= shift;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: rtl/uart_prog_loader.sv
// Framed UART program loader: A5, N, N x {lo,hi}, checksum -> program BRAM write port.
//
// state    | meaning
// LD_SYNC  | idle, waiting for the 0xA5 sync byte
// LD_COUNT | next byte is the word count N (0 = full memory)
// LD_LO    | next byte is a word's low byte
// LD_HI    | next byte is a word's high byte; the word is written after it
// LD_CSUM  | next byte is the checksum; sets done or err
module uart_prog_loader
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int ADDR_W       = 8,
    parameter int TIMEOUT_CLKS = 120000
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              rx,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              loading,
    output logic              done,
    output logic              err
);

    localparam int TMR_W = $clog2(TIMEOUT_CLKS);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CLKS - 1);

    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              frame_err;

    ld_state_t         state, state_nxt;
    logic [ADDR_W-1:0] index;
    logic [ADDR_W-1:0] last_idx;
    logic [7:0]        lo_byte;
    logic [7:0]        csum;
    logic [TMR_W-1:0]  tmr;
    logic              wr_fire, set_done, set_err, start_frame;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clock      (clock),
        .reset_n    (reset_n),
        .rx         (rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    assign loading = (state != LD_SYNC);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= LD_SYNC;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        wr_fire     = 1'b0;
        set_done    = 1'b0;
        set_err     = 1'b0;
        start_frame = 1'b0;
        case (state)
            LD_SYNC: begin
                if (byte_valid && byte_data == SYNC_BYTE) begin
                    start_frame = 1'b1;
                    state_nxt   = LD_COUNT;
                end
            end
            LD_COUNT: if (byte_valid) state_nxt = LD_LO;
            LD_LO:    if (byte_valid) state_nxt = LD_HI;
            LD_HI: begin
                if (byte_valid) begin
                    wr_fire   = 1'b1;
                    state_nxt = (index == last_idx) ? LD_CSUM : LD_LO;
                end
            end
            LD_CSUM: begin
                if (byte_valid) begin
                    set_done  = (byte_data == csum);
                    set_err   = (byte_data != csum);
                    state_nxt = LD_SYNC;
                end
            end
            default: state_nxt = LD_SYNC;
        endcase
        // byte_valid and frame_err are exclusive; byte_valid beats an expiring timer
        if (state != LD_SYNC && !byte_valid && (frame_err || tmr == '0)) begin
            set_err   = 1'b1;
            state_nxt = LD_SYNC;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            index    <= '0;
            last_idx <= '0;
            lo_byte  <= '0;
            csum     <= '0;
            tmr      <= '0;
        end else begin
            wr_en <= wr_fire;
            if (start_frame) begin
                done  <= 1'b0;
                err   <= 1'b0;
                index <= '0;
                csum  <= '0;
            end
            if (byte_valid) begin
                case (state)
                    LD_COUNT: begin
                        // N=0 wraps to all-ones, i.e. a full 2^ADDR_W-word load
                        last_idx <= ADDR_W'(byte_data - 8'd1);
                        csum     <= byte_data;
                    end
                    LD_LO: begin
                        lo_byte <= byte_data;
                        csum    <= csum + byte_data;
                    end
                    LD_HI: csum <= csum + byte_data;
                    default: ;
                endcase
            end
            if (wr_fire) begin
                wr_addr <= index;
                wr_data <= {byte_data, lo_byte};
                index   <= index + ADDR_W'(1);
            end
            if (set_done) done <= 1'b1;
            if (set_err)  err  <= 1'b1;
            if (byte_valid)               tmr <= TMR_LOAD;
            else if (loading && tmr != '0) tmr <= tmr - 1'b1;
        end
    end

endmodule
